ctrl_mem: RTL and testbench

- Memory-stage control for the 16-bit pipeline; sits directly upstream of the write-back control.
- Decodes the MEM-stage instruction register and sequences the data-memory request/acknowledge handshake for LDR/STR.
- Freezes the upstream pipeline while an access is outstanding.
- Registers the instruction into the WB-stage instruction register; a bubble is inserted while memory is busy.

---
 rtl/cpu_pkg.sv | 20 ++
 rtl/ctrl_mem.sv | 165 ++++++++++++++++
 tb/tb_ctrl_mem.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// ----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the 16-bit pipeline control blocks.
//   OP_LDR / OP_STR    : memory opcodes found in instruction bits [15:11]
//   NOP_INSTR          : bubble encoding for pipeline instruction registers
//   ctrl_mem_state_t   : state encoding of the memory-stage controller
// ----------------------------------------------------------------------------
package cpu_pkg;

    localparam logic [4:0]  OP_LDR    = 5'b01101;
    localparam logic [4:0]  OP_STR    = 5'b01110;
    localparam logic [15:0] NOP_INSTR = 16'h0000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_COMMIT
    } ctrl_mem_state_t;

endpackage

// File: rtl/ctrl_mem.sv
// ----------------------------------------------------------------------------
// ctrl_mem
// Memory-stage control. Decodes the MEM-stage instruction, runs the data
// memory request/acknowledge handshake for LDR/STR, freezes upstream stages
// while an access is outstanding and feeds the WB-stage instruction register
// (bubble while memory is busy).
//
// Ports:
//   clk          in   rising-edge clock
//   rst          in   synchronous reset, active low
//   i_stall      in   downstream/hazard stall; holds WB IR, blocks new access
//   i_ir_mem     in   [15:0] MEM-stage instruction register
//   i_mem_ack    in   data memory acknowledge (one cycle per access)
//   o_ir_wb      out  [15:0] WB-stage instruction register
//   o_mem_req    out  registered data memory request
//   o_mem_we     out  write enable, valid while o_mem_req is high
//   o_stall_req  out  combinational freeze request to upstream stages
//   o_mem_err    out  sticky access-abort flag (0 unless timeout enabled)
//
// Build option:
//   CTRL_MEM_TIMEOUT_EN  abort an access after TIMEOUT cycles without ack
// ----------------------------------------------------------------------------
module ctrl_mem #(
    parameter logic [15:0] NOP_INSTR = cpu_pkg::NOP_INSTR,
    parameter int unsigned TIMEOUT   = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_stall,
    input  logic [15:0] i_ir_mem,
    input  logic        i_mem_ack,
    output logic [15:0] o_ir_wb,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic        o_stall_req,
    output logic        o_mem_err
);

    import cpu_pkg::*;

    ctrl_mem_state_t state, state_nxt;

    logic [15:0] ir_hold, ir_hold_nxt;
    logic [15:0] ir_wb_nxt;
    logic        req_nxt;
    logic        we_nxt;
    logic        is_load;
    logic        is_store;

`ifdef CTRL_MEM_TIMEOUT_EN
    logic [15:0] cnt, cnt_nxt;
    logic        err_nxt;
`endif

    // Opcode decode
    always_comb begin
        is_load  = (i_ir_mem[15:11] == OP_LDR);
        is_store = (i_ir_mem[15:11] == OP_STR);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= ST_IDLE;
            o_ir_wb   <= NOP_INSTR;
            o_mem_req <= 1'b0;
            o_mem_we  <= 1'b0;
            ir_hold   <= NOP_INSTR;
`ifdef CTRL_MEM_TIMEOUT_EN
            cnt       <= '0;
            o_mem_err <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            o_ir_wb   <= ir_wb_nxt;
            o_mem_req <= req_nxt;
            o_mem_we  <= we_nxt;
            ir_hold   <= ir_hold_nxt;
`ifdef CTRL_MEM_TIMEOUT_EN
            cnt       <= cnt_nxt;
            o_mem_err <= err_nxt;
`endif
        end
    end

`ifndef CTRL_MEM_TIMEOUT_EN
    assign o_mem_err = 1'b0;
`endif

    always_comb begin
        state_nxt   = state;
        ir_wb_nxt   = o_ir_wb;
        req_nxt     = o_mem_req;
        we_nxt      = o_mem_we;
        ir_hold_nxt = ir_hold;
        o_stall_req = 1'b0;
`ifdef CTRL_MEM_TIMEOUT_EN
        cnt_nxt     = cnt;
        err_nxt     = o_mem_err;
`endif

        unique case (state)
            ST_IDLE: begin
                if (!i_stall) begin
                    if (is_load || is_store) begin
                        o_stall_req = 1'b1;
                        ir_hold_nxt = i_ir_mem;
                        req_nxt     = 1'b1;
                        we_nxt      = is_store;
                        ir_wb_nxt   = NOP_INSTR;
                        state_nxt   = ST_ACCESS;
`ifdef CTRL_MEM_TIMEOUT_EN
                        cnt_nxt     = '0;
`endif
                    end else begin
                        ir_wb_nxt = i_ir_mem;
                    end
                end
            end

            ST_ACCESS: begin
                o_stall_req = 1'b1;
                if (i_mem_ack) begin
                    req_nxt = 1'b0;
                    we_nxt  = 1'b0;
                    if (!i_stall) begin
                        // Release upstream in the ack cycle so it advances
                        // on the same edge that commits this instruction.
                        o_stall_req = 1'b0;
                        ir_wb_nxt   = ir_hold;
                        state_nxt   = ST_IDLE;
                    end else begin
                        state_nxt = ST_COMMIT;
                    end
                end
`ifdef CTRL_MEM_TIMEOUT_EN
                else if (cnt == 16'(TIMEOUT - 1)) begin
                    // Squash the instruction and let upstream move past it,
                    // otherwise the same access would be reissued.
                    o_stall_req = 1'b0;
                    req_nxt     = 1'b0;
                    we_nxt      = 1'b0;
                    err_nxt     = 1'b1;
                    ir_wb_nxt   = NOP_INSTR;
                    state_nxt   = ST_IDLE;
                end else begin
                    cnt_nxt = cnt + 16'd1;
                end
`endif
            end

            ST_COMMIT: begin
                o_stall_req = i_stall;
                if (!i_stall) begin
                    ir_wb_nxt = ir_hold;
                    state_nxt = ST_IDLE;
                end
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ctrl_mem.sv
module tb_ctrl_mem;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_stall;
    logic [15:0] i_ir_mem;
    logic        i_mem_ack;
    logic [15:0] o_ir_wb;
    logic        o_mem_req;
    logic        o_mem_we;
    logic        o_stall_req;
    logic        o_mem_err;

    int unsigned total = 0;
    int unsigned bad   = 0;

    always #5 clk = ~clk;

    ctrl_mem #(
        .NOP_INSTR(16'h0000),
        .TIMEOUT  (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i_stall    (i_stall),
        .i_ir_mem   (i_ir_mem),
        .i_mem_ack  (i_mem_ack),
        .o_ir_wb    (o_ir_wb),
        .o_mem_req  (o_mem_req),
        .o_mem_we   (o_mem_we),
        .o_stall_req(o_stall_req),
        .o_mem_err  (o_mem_err)
    );

    typedef struct {
        logic        stall;
        logic [15:0] ir;
        logic        ack;
        logic        exp_sr;   // o_stall_req in this cycle
        logic [15:0] exp_wb;   // after the edge
        logic        exp_req;  // after the edge
        logic        exp_we;   // after the edge
    } vec_t;

    vec_t vecs[20];

    task automatic chk(input string nm, input int idx, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d] actual=%h required=%h", nm, idx, act, exp);
        end
    endtask

    // Called at posedge+1: drive inputs, check comb stall, clock, check regs.
    task automatic cyc(input int idx, input logic st, input logic [15:0] ir, input logic ak,
                       input logic e_sr, input logic [15:0] e_wb, input logic e_req,
                       input logic e_we, input logic e_err);
        i_stall   = st;
        i_ir_mem  = ir;
        i_mem_ack = ak;
        #1;
        chk("stall_req", idx, {15'd0, o_stall_req}, {15'd0, e_sr});
        @(posedge clk);
        #1;
        chk("ir_wb", idx, o_ir_wb, e_wb);
        chk("mem_req", idx, {15'd0, o_mem_req}, {15'd0, e_req});
        chk("mem_we", idx, {15'd0, o_mem_we}, {15'd0, e_we});
        chk("mem_err", idx, {15'd0, o_mem_err}, {15'd0, e_err});
    endtask

    task automatic do_reset();
        rst       = 1'b0;
        i_stall   = 1'b0;
        i_ir_mem  = 16'h0000;
        i_mem_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        //            stall ir        ack  sr   wb        req  we
        vecs[0]  = '{1'b0, 16'h1234, 1'b0, 1'b0, 16'h1234, 1'b0, 1'b0}; // ALU op
        vecs[1]  = '{1'b0, 16'h6A05, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0}; // LDR issue
        vecs[2]  = '{1'b0, 16'h6A05, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0}; // ACCESS 1
        vecs[3]  = '{1'b0, 16'h6A05, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0}; // ACCESS 2
        vecs[4]  = '{1'b0, 16'h6A05, 1'b1, 1'b0, 16'h6A05, 1'b0, 1'b0}; // ACCESS 3 ack
        vecs[5]  = '{1'b0, 16'h7001, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b1}; // STR issue
        vecs[6]  = '{1'b1, 16'h7001, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b0}; // ack under stall
        vecs[7]  = '{1'b1, 16'h7001, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b0}; // COMMIT, ack ignored
        vecs[8]  = '{1'b1, 16'h7001, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0}; // COMMIT
        vecs[9]  = '{1'b0, 16'h7001, 1'b0, 1'b0, 16'h7001, 1'b0, 1'b0}; // stall falls
        vecs[10] = '{1'b0, 16'h6800, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0}; // LDR issue
        vecs[11] = '{1'b0, 16'h6800, 1'b1, 1'b0, 16'h6800, 1'b0, 1'b0}; // immediate ack
        vecs[12] = '{1'b0, 16'h7123, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b1}; // STR from IDLE
        vecs[13] = '{1'b0, 16'h7123, 1'b1, 1'b0, 16'h7123, 1'b0, 1'b0}; // its own ack
        vecs[14] = '{1'b1, 16'h2222, 1'b0, 1'b0, 16'h7123, 1'b0, 1'b0}; // IDLE stall holds
        vecs[15] = '{1'b1, 16'h6900, 1'b0, 1'b0, 16'h7123, 1'b0, 1'b0}; // LDR blocked by stall
        vecs[16] = '{1'b0, 16'h1111, 1'b1, 1'b0, 16'h1111, 1'b0, 1'b0}; // IDLE ack ignored
        vecs[17] = '{1'b0, 16'h6A05, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0}; // LDR issue
        vecs[18] = '{1'b1, 16'h6A05, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0}; // stall, no ack
        vecs[19] = '{1'b0, 16'h6A05, 1'b1, 1'b0, 16'h6A05, 1'b0, 1'b0}; // ack

        do_reset();
        chk("rst_ir_wb", 0, o_ir_wb, 16'h0000);
        chk("rst_mem_req", 0, {15'd0, o_mem_req}, 16'd0);
        chk("rst_stall_req", 0, {15'd0, o_stall_req}, 16'd0);
        chk("rst_mem_err", 0, {15'd0, o_mem_err}, 16'd0);

        foreach (vecs[i])
            cyc(i, vecs[i].stall, vecs[i].ir, vecs[i].ack,
                vecs[i].exp_sr, vecs[i].exp_wb, vecs[i].exp_req, vecs[i].exp_we, 1'b0);

        // Reset mid-access drops the request at once.
        cyc(100, 1'b0, 16'h7002, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_req", 101, {15'd0, o_mem_req}, 16'd0);
        chk("midrst_we", 101, {15'd0, o_mem_we}, 16'd0);
        chk("midrst_wb", 101, o_ir_wb, 16'h0000);
        rst      = 1'b1;
        i_ir_mem = 16'h0000;
        cyc(102, 1'b0, 16'h4321, 1'b0, 1'b0, 16'h4321, 1'b0, 1'b0, 1'b0);

`ifdef CTRL_MEM_TIMEOUT_EN
        // Ack on the final allowed cycle wins over the timeout.
        do_reset();
        cyc(200, 1'b0, 16'h6A05, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++)
            cyc(201 + k, 1'b0, 16'h6A05, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0);
        cyc(204, 1'b0, 16'h6A05, 1'b1, 1'b0, 16'h6A05, 1'b0, 1'b0, 1'b0);

        // No ack: request held 4 ACCESS cycles, then abort with sticky error.
        cyc(300, 1'b0, 16'h6A05, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++)
            cyc(301 + k, 1'b0, 16'h6A05, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0);
        cyc(304, 1'b0, 16'h6A05, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
        cyc(305, 1'b0, 16'h1234, 1'b0, 1'b0, 16'h1234, 1'b0, 1'b0, 1'b1);
        cyc(306, 1'b0, 16'h5555, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
